// File: rtl/mem_sa_dbuf.sv
// Per-subaddress double-buffered message store: the protocol side fills a shadow bank
// and commits atomically, the host side reads the last committed message from the active bank.
module mem_sa_dbuf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CH_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_WIDTH-1:0]   wr_ch,
  input  logic                  wr_start,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  output logic                  wr_busy,
  output logic                  wr_err,
  input  logic [CH_WIDTH-1:0]   rd_ch,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_new,
  output logic                  rd_lost,
  input  logic                  rd_ack
);

  localparam int NCH   = 2**CH_WIDTH;
  localparam int DEPTH = 2**(CH_WIDTH+1+ADDR_WIDTH);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CH_WIDTH-1:0]   wch;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  ovf;

  logic [NCH-1:0]        act_bank;
  logic [NCH-1:0]        newf;
  logic [NCH-1:0]        lost;
  logic [ADDR_WIDTH:0]   count [NCH];

  logic filling, accept, ovf_now, end_commit, commit_ok, commit_bad;
  logic [CH_WIDTH+ADDR_WIDTH:0] wr_addr_full, rd_addr_full;
  logic [ADDR_WIDTH:0]          commit_cnt;

  // wptr MSB set means the bank is full, so further words overflow
  assign filling      = (state == FILL);
  assign accept       = filling & wr_en & ~wptr[ADDR_WIDTH];
  assign ovf_now      = filling & wr_en &  wptr[ADDR_WIDTH];
  assign end_commit   = filling & wr_commit & ~wr_abort;
  assign commit_ok    = end_commit & ~ovf & ~ovf_now;
  assign commit_bad   = end_commit & (ovf | ovf_now);
  assign commit_cnt   = wptr + {{ADDR_WIDTH{1'b0}}, accept};
  assign wr_addr_full = {wch, ~act_bank[wch], wptr[ADDR_WIDTH-1:0]};
  assign rd_addr_full = {rd_ch, act_bank[rd_ch], rd_addr};

  assign rd_count = count[rd_ch];
  assign rd_new   = newf[rd_ch];
  assign rd_lost  = lost[rd_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wr_start) state_nxt = FILL;
      FILL: if (wr_abort || wr_commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_busy = (state == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wch    <= '0;
      wptr   <= '0;
      ovf    <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= commit_bad;
      if (state == IDLE && wr_start) begin
        wch  <= wr_ch;
        wptr <= '0;
        ovf  <= 1'b0;
      end else begin
        if (accept)  wptr <= wptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (ovf_now) ovf  <= 1'b1;
      end
    end
  end

  // A commit and an ack on the same channel in one cycle leave the new message pending but not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_bank <= '0;
      newf     <= '0;
      lost     <= '0;
      for (int i = 0; i < NCH; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_ok && wch == CH_WIDTH'(i)) begin
          act_bank[i] <= ~act_bank[i];
          count[i]    <= commit_cnt;
          newf[i]     <= 1'b1;
          lost[i]     <= (rd_ack && rd_ch == CH_WIDTH'(i)) ? 1'b0 : (lost[i] | newf[i]);
        end else if (rd_ack && rd_ch == CH_WIDTH'(i)) begin
          newf[i] <= 1'b0;
          lost[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr_full] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr_full];
    end
  end

endmodule

// File: tb/tb_mem_sa_dbuf.sv
// Scoreboard bench for mem_sa_dbuf: read expectations are queued from a data model when
// rd_en is driven and popped when rd_valid is due; status outputs are compared to constants.
module tb_mem_sa_dbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_ch;
  logic        wr_start, wr_en, wr_commit, wr_abort;
  logic [15:0] wr_data;
  logic        wr_busy, wr_err;
  logic [1:0]  rd_ch;
  logic [4:0]  rd_addr;
  logic        rd_en, rd_ack;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [5:0]  rd_count;
  logic        rd_new, rd_lost;

  mem_sa_dbuf dut (
    .clk(clk), .rst(rst),
    .wr_ch(wr_ch), .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_abort(wr_abort), .wr_busy(wr_busy), .wr_err(wr_err),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_count(rd_count), .rd_new(rd_new), .rd_lost(rd_lost),
    .rd_ack(rd_ack)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] sb [$];
  bit          rvExp  = 1'b0;
  bit          errExp = 1'b0;

  logic [15:0] mdlData [4][32];
  logic [15:0] fillBuf [32];
  bit          fillAct = 1'b0;
  bit          fillOvf;
  logic [1:0]  fillCh;
  int          fillPtr;

  bit          sStart, sEn, sCommit, sAbort, sRdEn, sAck;
  logic [1:0]  sWch, sRch;
  logic [15:0] sData;
  logic [4:0]  sRaddr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    checkOutput("rd_valid", {31'b0, rd_valid}, {31'b0, rvExp});
    checkOutput("wr_err", {31'b0, wr_err}, {31'b0, errExp});
    if (rvExp && sb.size() > 0) checkOutput("rd_data", {16'b0, rd_data}, {16'b0, sb.pop_front()});
  end

  task automatic zeroInputs();
    wr_ch = '0; wr_start = 0; wr_en = 0; wr_data = '0; wr_commit = 0; wr_abort = 0;
    rd_ch = '0; rd_addr = '0; rd_en = 0; rd_ack = 0;
  endtask

  task automatic clearStim();
    sStart = 0; sEn = 0; sCommit = 0; sAbort = 0; sRdEn = 0; sAck = 0;
    sWch = '0; sRch = '0; sData = '0; sRaddr = '0;
  endtask

  task automatic applyStimulus();
    bit acc, ovfNow;
    int after;
    @(negedge clk); #1;
    rvExp  = sRdEn;
    errExp = 1'b0;
    if (sRdEn) sb.push_back(mdlData[sRch][sRaddr]);
    if (!fillAct) begin
      if (sStart) begin
        fillAct = 1; fillCh = sWch; fillPtr = 0; fillOvf = 0;
      end
    end else begin
      acc    = sEn && fillPtr < 32;
      ovfNow = sEn && fillPtr >= 32;
      if (acc) fillBuf[fillPtr] = sData;
      after = fillPtr + (acc ? 1 : 0);
      if (sAbort) fillAct = 0;
      else if (sCommit) begin
        fillAct = 0;
        if (fillOvf || ovfNow) errExp = 1'b1;
        else for (int i = 0; i < after; i++) mdlData[fillCh][i] = fillBuf[i];
      end else begin
        fillPtr = after;
        if (ovfNow) fillOvf = 1;
      end
    end
    wr_start = sStart; wr_ch = sWch; wr_en = sEn; wr_data = sData;
    wr_commit = sCommit; wr_abort = sAbort;
    rd_en = sRdEn; rd_ch = sRch; rd_addr = sRaddr; rd_ack = sAck;
    @(posedge clk);
    clearStim();
  endtask

  task automatic checkStatus(input logic [1:0] ch, input int cnt, input bit nw, input bit lst, input bit busy);
    @(negedge clk); #1;
    zeroInputs();
    rd_ch = ch; rvExp = 0; errExp = 0;
    #1;
    checkOutput($sformatf("count_ch%0d", ch), {26'b0, rd_count}, cnt);
    checkOutput($sformatf("new_ch%0d", ch), {31'b0, rd_new}, {31'b0, nw});
    checkOutput($sformatf("lost_ch%0d", ch), {31'b0, rd_lost}, {31'b0, lst});
    checkOutput("wr_busy", {31'b0, wr_busy}, {31'b0, busy});
    @(posedge clk);
  endtask

  task automatic readWord(input logic [1:0] ch, input logic [4:0] addr);
    sRdEn = 1; sRch = ch; sRaddr = addr; applyStimulus();
  endtask

  task automatic startMsg(input logic [1:0] ch);
    sStart = 1; sWch = ch; applyStimulus();
  endtask

  task automatic writeWord(input logic [15:0] d);
    sEn = 1; sData = d; applyStimulus();
  endtask

  task automatic commitMsg();
    sCommit = 1; applyStimulus();
  endtask

  // Reset lands just after an active edge, so rd_valid from the preceding read is cleared early
  task automatic pulseReset();
    #2;
    rst = 1; zeroInputs();
    rvExp = 0; errExp = 0; fillAct = 0; sb.delete();
    #1;
    checkOutput("rst_busy", {31'b0, wr_busy}, 32'd0);
    checkOutput("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    @(negedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1;
    zeroInputs();
    clearStim();
    repeat (2) @(negedge clk);
    #1 rst = 0;
    checkOutput("reset_rd_data", {16'b0, rd_data}, 32'd0);
    for (int c = 0; c < 4; c++) checkStatus(2'(c), 0, 0, 0, 0);

    $display("[TB] ch1 first message");
    startMsg(2'd1);
    for (int i = 0; i < 3; i++) writeWord(16'(16'hA001 + i));
    commitMsg();
    checkStatus(2'd1, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) readWord(2'd1, 5'(i));

    $display("[TB] ch1 second message held open");
    startMsg(2'd1);
    writeWord(16'hB001);
    writeWord(16'hB002);
    checkStatus(2'd1, 3, 1, 0, 1);
    for (int i = 0; i < 3; i++) readWord(2'd1, 5'(i));
    commitMsg();
    checkStatus(2'd1, 2, 1, 1, 0);
    readWord(2'd1, 5'd0);
    readWord(2'd1, 5'd1);

    $display("[TB] ch2 abort");
    startMsg(2'd2);
    for (int i = 0; i < 5; i++) writeWord(16'(16'hC000 + i));
    sAbort = 1; applyStimulus();
    checkStatus(2'd2, 0, 0, 0, 0);
    checkStatus(2'd1, 2, 1, 1, 0);
    readWord(2'd1, 5'd1);

    $display("[TB] ch0 overflow then full buffer");
    startMsg(2'd0);
    for (int i = 0; i < 33; i++) writeWord(16'(16'hD000 + i));
    commitMsg();
    checkStatus(2'd0, 0, 0, 0, 0);
    startMsg(2'd0);
    for (int i = 0; i < 32; i++) writeWord(16'(16'hE000 + i));
    commitMsg();
    checkStatus(2'd0, 32, 1, 0, 0);
    readWord(2'd0, 5'd0);
    readWord(2'd0, 5'd31);

    $display("[TB] ch3 same-cycle read, commit and last write");
    startMsg(2'd3);
    writeWord(16'h3D00);
    commitMsg();
    startMsg(2'd3);
    writeWord(16'h3E00);
    writeWord(16'h3E01);
    sEn = 1; sData = 16'h3E02; sCommit = 1;
    sRdEn = 1; sRch = 2'd3; sRaddr = 5'd0;
    applyStimulus();
    checkStatus(2'd3, 3, 1, 1, 0);
    readWord(2'd3, 5'd2);
    startMsg(2'd3);
    writeWord(16'h3F00);
    sCommit = 1; sAck = 1; sRch = 2'd3;
    applyStimulus();
    checkStatus(2'd3, 1, 1, 0, 0);
    readWord(2'd3, 5'd0);
    sAck = 1; sRch = 2'd3; applyStimulus();
    checkStatus(2'd3, 1, 0, 0, 0);

    $display("[TB] reset during fill");
    startMsg(2'd2);
    for (int i = 0; i < 4; i++) writeWord(16'(16'h2000 + i));
    readWord(2'd1, 5'd0);
    pulseReset();
    for (int c = 0; c < 4; c++) checkStatus(2'(c), 0, 0, 0, 0);
    startMsg(2'd2);
    writeWord(16'h2A00);
    writeWord(16'h2A01);
    commitMsg();
    checkStatus(2'd2, 2, 1, 0, 0);
    readWord(2'd2, 5'd1);
    readWord(2'd2, 5'd0);

    applyStimulus();
    applyStimulus();
    @(negedge clk); #1;
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
